// File: rtl/stream_arbiter4.sv
// Four-input round-robin stream arbiter. Each grant covers a burst of BURST_LEN
// beats, forwarded through one registered output stage tagged with source and last.
module stream_arbiter4 #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    input  logic [DATA_WIDTH-1:0] data_in4,
    input  logic                  data_in1_valid,
    input  logic                  data_in2_valid,
    input  logic                  data_in3_valid,
    input  logic                  data_in4_valid,
    output logic                  data_in1_ready,
    output logic                  data_in2_ready,
    output logic                  data_in3_ready,
    output logic                  data_in4_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic [1:0]            data_out_src,
    output logic                  data_out_last,
    output logic                  busy
);
    // Handshake: a beat moves on a port in any cycle where valid and ready are both
    // high at the rising edge; ready never depends on the same port's valid.
    typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

    localparam logic [CNT_WIDTH-1:0] LP_LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_grant;
    logic [1:0]            r_last_grant;
    logic [1:0]            w_pick;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [1:0]            r_out_src;
    logic [DATA_WIDTH-1:0] w_din [4];
    logic [3:0]            w_vld;
    logic [3:0]            w_rdy;
    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_beat_last;
    logic                  w_busy;

    assign w_din[0]    = data_in1;
    assign w_din[1]    = data_in2;
    assign w_din[2]    = data_in3;
    assign w_din[3]    = data_in4;
    assign w_vld       = {data_in4_valid, data_in3_valid, data_in2_valid, data_in1_valid};
    assign w_out_free  = ~r_out_valid | data_out_ready;
    assign w_beat_last = (r_beat_cnt == LP_LAST_BEAT);
    assign w_accept    = w_vld[r_grant] & w_rdy[r_grant];

    // Scan downwards so the nearest requester after last_grant wins.
    always_comb begin
        logic [1:0] v_idx;
        v_idx  = '0;
        w_pick = r_last_grant;
        for (int k = 4; k >= 1; k--) begin
            v_idx = r_last_grant + 2'(k);
            if (w_vld[v_idx]) w_pick = v_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|w_vld) w_state_nxt = S_BURST;
            S_BURST: if (w_accept && w_beat_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdy  = '0;
        w_busy = (r_state == S_BURST);
        if (w_busy && w_out_free) w_rdy[r_grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= 2'd0;
            r_last_grant <= 2'd3;
            r_beat_cnt   <= '0;
        end else if (r_state == S_IDLE) begin
            if (|w_vld) begin
                r_grant    <= w_pick;
                r_beat_cnt <= '0;
            end
        end else if (w_accept) begin
            if (w_beat_last) begin
                r_last_grant <= r_grant;
                r_beat_cnt   <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // A beat consumed in the same cycle as a new accept is simply overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= 2'd0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_data_out  <= w_din[r_grant];
            r_out_valid <= 1'b1;
            r_out_src   <= r_grant;
            r_out_last  <= w_beat_last;
        end else if (data_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign data_in1_ready = w_rdy[0];
    assign data_in2_ready = w_rdy[1];
    assign data_in3_ready = w_rdy[2];
    assign data_in4_ready = w_rdy[3];
    assign data_out       = r_data_out;
    assign data_out_valid = r_out_valid;
    assign data_out_src   = r_out_src;
    assign data_out_last  = r_out_last;
    assign busy           = w_busy;

endmodule

// File: tb/tb_stream_arbiter4.sv
// Bench for stream_arbiter4: a cycle table for the single-requester case, a beat
// scoreboard on the output, and directed sequences for the multi-cycle corners.
module tb_stream_arbiter4;
    localparam int DW   = 32;
    localparam int SB_W = DW + 3;

    typedef struct {
        logic [3:0]    vld;
        logic          odr;
        logic [DW-1:0] d3;
        logic [3:0]    e_rdy;
        logic          e_busy;
        logic          e_ov;
        logic [1:0]    e_src;
        logic          e_last;
        logic [DW-1:0] e_d;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] din [4];
    logic [3:0]    vin;
    wire  [3:0]    rdy;
    wire  [DW-1:0] dout;
    wire           dout_valid;
    logic          dout_ready;
    wire  [1:0]    dout_src;
    wire           dout_last;
    wire           busy;

    logic [DW-1:0] din_b [4];
    logic [3:0]    vin_b;
    wire  [3:0]    rdy_b;
    wire  [DW-1:0] dout_b;
    wire           dout_valid_b;
    logic          dout_ready_b;
    wire  [1:0]    dout_src_b;
    wire           dout_last_b;
    wire           busy_b;

    logic [SB_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int beats_seen, first_cyc, last_cyc;
    int cnt [4];
    int lim [4];
    logic [3:0] en, gap, hs;
    bit auto_mode;
    vec_t tbl [7];

    stream_arbiter4 #(.DATA_WIDTH(DW), .BURST_LEN(4), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .data_in1(din[0]), .data_in2(din[1]), .data_in3(din[2]), .data_in4(din[3]),
        .data_in1_valid(vin[0]), .data_in2_valid(vin[1]),
        .data_in3_valid(vin[2]), .data_in4_valid(vin[3]),
        .data_in1_ready(rdy[0]), .data_in2_ready(rdy[1]),
        .data_in3_ready(rdy[2]), .data_in4_ready(rdy[3]),
        .data_out(dout), .data_out_valid(dout_valid), .data_out_ready(dout_ready),
        .data_out_src(dout_src), .data_out_last(dout_last), .busy(busy)
    );

    stream_arbiter4 #(.DATA_WIDTH(DW), .BURST_LEN(1), .CNT_WIDTH(8)) u_dut1 (
        .clk(clk), .rst(rst),
        .data_in1(din_b[0]), .data_in2(din_b[1]), .data_in3(din_b[2]), .data_in4(din_b[3]),
        .data_in1_valid(vin_b[0]), .data_in2_valid(vin_b[1]),
        .data_in3_valid(vin_b[2]), .data_in4_valid(vin_b[3]),
        .data_in1_ready(rdy_b[0]), .data_in2_ready(rdy_b[1]),
        .data_in3_ready(rdy_b[2]), .data_in4_ready(rdy_b[3]),
        .data_out(dout_b), .data_out_valid(dout_valid_b), .data_out_ready(dout_ready_b),
        .data_out_src(dout_src_b), .data_out_last(dout_last_b), .busy(busy_b)
    );

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Output monitor: every consumed beat must match the head of the expected queue.
    always @(negedge clk) begin
        hs = vin & rdy;
        if (!rst) begin
            check("rdy_onehot", 64'($countones(rdy) <= 1), 64'd1);
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_extra: got src=%0d data=0x%0h expected no beat", dout_src, dout);
                end else begin
                    check("sb_beat", 64'({dout_src, dout_last, dout}), 64'(exp_q.pop_front()));
                end
                beats_seen++;
                if (beats_seen == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
    end

    task automatic push(input int src, input bit last, input int d);
        exp_q.push_back({2'(src), last, DW'(d)});
    endtask

    task automatic push_burst(input int i);
        for (int k = 0; k < 4; k++) push(i, (k == 3), (i + 1) * 256 + k);
    endtask

    task automatic drive_auto;
        for (int i = 0; i < 4; i++) begin
            vin[i] = en[i] && !gap[i] && (cnt[i] < lim[i]);
            din[i] = DW'((i + 1) * 256 + cnt[i]);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (auto_mode) begin
            for (int i = 0; i < 4; i++) if (hs[i]) cnt[i]++;
            drive_auto();
        end
        #1;
    endtask

    task automatic do_reset(input bit am);
        auto_mode  = am;
        en         = '0;
        gap        = '0;
        vin        = '0;
        vin_b      = '0;
        beats_seen = 0;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            lim[i] = 4;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            tick();
            guard++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int guard;
        bit gapped;
        int gap_left;
        rst          = 1'b1;
        dout_ready   = 1'b1;
        dout_ready_b = 1'b1;
        hs           = '0;
        for (int i = 0; i < 4; i++) begin
            din[i]   = '0;
            din_b[i] = '0;
        end
        din_b[0] = 32'hA1;
        din_b[1] = 32'hB2;

        // Reset values, both builds.
        do_reset(1'b0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_src", 64'(dout_src), 64'd0);
        check("rst_last", 64'(dout_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdy", 64'(rdy), 64'd0);
        check("rst_valid_b", 64'(dout_valid_b), 64'd0);

        // Single requester on input 3, one row per clock.
        tbl[0] = '{4'b0100, 1'b1, 32'h30, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 32'h00};
        tbl[1] = '{4'b0100, 1'b1, 32'h30, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 32'h00};
        tbl[2] = '{4'b0100, 1'b1, 32'h31, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 32'h30};
        tbl[3] = '{4'b0100, 1'b1, 32'h32, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 32'h31};
        tbl[4] = '{4'b0100, 1'b1, 32'h33, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 32'h32};
        tbl[5] = '{4'b0000, 1'b1, 32'h33, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, 32'h33};
        tbl[6] = '{4'b0000, 1'b1, 32'h33, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 32'h33};
        for (int k = 0; k < 4; k++) push(2, (k == 3), 32'h30 + k);
        for (int r = 0; r < 7; r++) begin
            vin        = tbl[r].vld;
            din[2]     = tbl[r].d3;
            dout_ready = tbl[r].odr;
            #1;
            check($sformatf("t1_rdy[%0d]", r), 64'(rdy), 64'(tbl[r].e_rdy));
            check($sformatf("t1_busy[%0d]", r), 64'(busy), 64'(tbl[r].e_busy));
            check($sformatf("t1_valid[%0d]", r), 64'(dout_valid), 64'(tbl[r].e_ov));
            check($sformatf("t1_out[%0d]", r), 64'({dout_src, dout_last, dout}),
                  64'({tbl[r].e_src, tbl[r].e_last, tbl[r].e_d}));
            tick();
        end
        check("t1_drain", 64'(exp_q.size()), 64'd0);

        // All four requesting: bursts in order 1,2,3,4 with one idle gap between.
        do_reset(1'b1);
        en = 4'b1111;
        drive_auto();
        for (int i = 0; i < 4; i++) push_burst(i);
        wait_drain("rr_drain");
        check("rr_beats", 64'(beats_seen), 64'd16);
        check("rr_span", 64'(last_cyc - first_cyc), 64'd18);
        tick();
        check("rr_idle", 64'(busy), 64'd0);

        // Backpressure on the second beat for five cycles.
        do_reset(1'b1);
        en = 4'b0001;
        drive_auto();
        push_burst(0);
        guard = 0;
        while (!(dout_valid && dout == 32'h101) && guard < 50) begin
            tick();
            guard++;
        end
        check("bp_found", 64'(dout_valid && dout == 32'h101), 64'd1);
        dout_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_hold_data", 64'({dout_valid, dout_src, dout}), 64'({1'b1, 2'd0, 32'h101}));
            check("bp_rdy", 64'(rdy), 64'd0);
            tick();
        end
        check("bp_hold_end", 64'({dout_valid, dout}), 64'({1'b1, 32'h101}));
        dout_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_beats", 64'(beats_seen), 64'd4);

        // Granted input 2 gaps mid-burst; input 4 must not be served meanwhile.
        do_reset(1'b1);
        en = 4'b1010;
        drive_auto();
        push_burst(1);
        push_burst(3);
        gapped   = 1'b0;
        gap_left = 0;
        guard    = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            tick();
            guard++;
            if (cnt[1] == 2 && !gapped) begin
                gapped   = 1'b1;
                gap_left = 3;
            end
            gap[1] = (gap_left > 0);
            if (gap_left > 0) gap_left--;
            drive_auto();
            #1;
            if (cnt[1] < 4) check("no_preempt", 64'(rdy[3]), 64'd0);
        end
        check("gap_drain", 64'(exp_q.size()), 64'd0);
        check("gap_seen", 64'(gapped), 64'd1);

        // Reset mid-burst with a beat still pending on the output.
        do_reset(1'b1);
        en = 4'b0001;
        drive_auto();
        push(0, 1'b0, 32'h100);
        guard = 0;
        while (cnt[0] != 2 && guard < 50) begin
            tick();
            guard++;
        end
        check("mr_pre_valid", 64'({dout_valid, dout}), 64'({1'b1, 32'h101}));
        dout_ready = 1'b0;
        en         = 4'b0000;
        rst        = 1'b1;
        drive_auto();
        tick();
        check("mr_outs", 64'({dout_valid, dout_src, dout_last, dout}), 64'd0);
        check("mr_busy_rdy", 64'({busy, rdy}), 64'd0);
        check("mr_sb_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        rst        = 1'b0;
        dout_ready = 1'b1;
        en         = 4'b1010;
        drive_auto();
        tick();
        check("mr_grant2", 64'({busy, rdy}), 64'({1'b1, 4'b0010}));
        push_burst(1);
        push_burst(3);
        wait_drain("mr_drain");

        // Same, but input 1 also requesting: it takes the first grant.
        do_reset(1'b1);
        en = 4'b1011;
        drive_auto();
        tick();
        check("mr_grant1", 64'({busy, rdy}), 64'({1'b1, 4'b0001}));
        push_burst(0);
        push_burst(1);
        push_burst(3);
        wait_drain("mr1_drain");

        // BURST_LEN=1 build: inputs 1 and 2 alternate, one beat every two cycles.
        do_reset(1'b0);
        vin_b = 4'b0011;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k % 2 == 0) begin
                check($sformatf("b1_beat[%0d]", k),
                      64'({dout_valid_b, dout_src_b, dout_last_b, dout_b}),
                      64'({1'b1, 2'(((k / 2) - 1) % 2), 1'b1,
                           (((k / 2) - 1) % 2 == 0) ? 32'hA1 : 32'hB2}));
            end else begin
                check($sformatf("b1_gap[%0d]", k), 64'(dout_valid_b), 64'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
